// File: rtl/wave_warp_pipe.sv
// wave_warp_pipe: 3-stage row-dependent horizontal warp with per-frame mode/amp shadows.
// Build with WAVE_ANIMATE_EN defined to add a per-frame row phase that scrolls the wave.
module wave_warp_pipe #(
    parameter int H_ACTIVE = 240,
    parameter int V_ACTIVE = 320,
    parameter int PIX_W    = 7,
    parameter int SH_OUTER = 3,
    parameter int SH_MID   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             data_valid_in,
    input  logic [PIX_W-1:0] data_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic [1:0]       mode_in,
    input  logic [2:0]       amp_in,
    output logic             data_valid_out,
    output logic [PIX_W-1:0] pixel_out,
    output logic [10:0]      hcount_out,
    output logic [9:0]       vcount_out
);

    localparam logic [10:0]        H_ACT_U  = 11'(H_ACTIVE);
    localparam logic [10:0]        H_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [9:0]         V_ACT_U  = 10'(V_ACTIVE);
    localparam logic signed [12:0] HALF_S   = 13'(V_ACTIVE / 2);
    localparam logic signed [12:0] VA_S     = 13'(V_ACTIVE);
    localparam logic signed [12:0] HA_S     = 13'(H_ACTIVE);
    localparam logic signed [12:0] DS_MAX13 = 13'(H_ACTIVE - 1);
    localparam logic signed [29:0] DS_MAX30 = 30'(H_ACTIVE - 1);

    typedef struct packed {
        logic               valid;
        logic [PIX_W-1:0]   pix;
        logic [9:0]         v;
        logic               oor;
        logic [10:0]        base;
        logic [2:0]         amp;
        logic signed [12:0] fa;
        logic signed [12:0] fb;
    } s1_t;

    typedef struct packed {
        logic               valid;
        logic [PIX_W-1:0]   pix;
        logic [9:0]         v;
        logic               oor;
        logic [10:0]        base;
        logic signed [12:0] ds;
    } s2_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;

    logic [1:0]       mode_q, mode_d;
    logic [2:0]       amp_q, amp_d;
    logic             valid_out_q, valid_out_d;
    logic [PIX_W-1:0] pixel_out_q, pixel_out_d;
    logic [10:0]      hcount_out_q, hcount_out_d;
    logic [9:0]       vcount_out_q, vcount_out_d;

    logic               frame_start;
    logic [1:0]         mode_eff;
    logic [2:0]         amp_eff;
    logic [9:0]         v_eff;
    logic               oor;
    logic signed [12:0] v_s, mid, top, bot, zig;
    logic [4:0]         zm, zt;

`ifdef WAVE_ANIMATE_EN
    localparam int PH_W = $clog2(V_ACTIVE);
    logic [PH_W-1:0] phase_q, phase_d;
    logic [10:0]     v_sum, v_wrap;
    logic            unused_vwrap;

    assign unused_vwrap = v_wrap[10];

    always_comb begin
        v_sum   = {1'b0, vcount_in} + 11'(phase_q);
        v_wrap  = (v_sum >= {1'b0, V_ACT_U}) ? v_sum - {1'b0, V_ACT_U} : v_sum;
        phase_d = phase_q;
        if (frame_start) begin
            phase_d = (phase_q == PH_W'(V_ACTIVE - 1)) ? '0 : phase_q + 1'b1;
        end
    end

    // Frame-start pixel still sees the old phase; the step shows up next frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign v_eff = v_wrap[9:0];
`else
    assign v_eff = vcount_in;
`endif

    // Stage 1: shadow select, row terms, factor pair for the stage-2 multiply
    always_comb begin
        frame_start = data_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
        mode_eff    = frame_start ? mode_in : mode_q;
        amp_eff     = frame_start ? amp_in : amp_q;
        mode_d      = mode_eff;
        amp_d       = amp_eff;
        oor         = (hcount_in >= H_ACT_U) || (vcount_in >= V_ACT_U);

        v_s = $signed({3'b000, v_eff});
        mid = (v_s - HALF_S) >>> SH_MID;
        top = (v_s - VA_S) >>> SH_OUTER;
        bot = (-v_s) >>> SH_OUTER;
        zm  = v_eff[4:0];
        zt  = (zm < 5'd16) ? zm : 5'd31 - zm;
        zig = $signed({8'b0, zt}) - 13'sd8;

        s1_d       = '0;
        s1_d.valid = data_valid_in;
        s1_d.pix   = data_in;
        s1_d.v     = vcount_in;
        s1_d.oor   = oor;
        s1_d.amp   = amp_eff;
        s1_d.base  = (!oor && mode_eff == 2'd2) ? H_LAST - hcount_in : hcount_in;
        if (!oor) begin
            unique case (mode_eff)
                2'd0: begin
                    s1_d.fa = '0;
                    s1_d.fb = '0;
                end
                2'd1, 2'd2: begin
                    s1_d.fa = mid;
                    s1_d.fb = (v_s > HALF_S) ? top : bot;
                end
                2'd3: begin
                    s1_d.fa = zig;
                    s1_d.fb = 13'sd1;
                end
            endcase
        end
    end

    logic signed [25:0] prod;
    logic signed [29:0] prod_w, amp_w, scaled, shifted;

    // Stage 2: offset, gain in quarters, clamp
    always_comb begin
        prod    = $signed(s1_q.fa) * $signed(s1_q.fb);
        prod_w  = {{4{prod[25]}}, prod};
        amp_w   = {27'b0, s1_q.amp};
        scaled  = prod_w * amp_w;
        shifted = scaled >>> 2;

        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.pix   = s1_q.pix;
        s2_d.v     = s1_q.v;
        s2_d.oor   = s1_q.oor;
        s2_d.base  = s1_q.base;
        if (shifted > DS_MAX30) begin
            s2_d.ds = DS_MAX13;
        end else if (shifted < -DS_MAX30) begin
            s2_d.ds = -DS_MAX13;
        end else begin
            s2_d.ds = shifted[12:0];
        end
    end

    logic signed [12:0] x, x_w;
    logic [1:0]         unused_x;

    assign unused_x = x_w[12:11];

    // Stage 3: add and wrap; idle outputs are forced to zero
    always_comb begin
        x = $signed({2'b00, s2_q.base}) + $signed(s2_q.ds);
        if (x >= HA_S) begin
            x_w = x - HA_S;
        end else if (x < 13'sd0) begin
            x_w = x + HA_S;
        end else begin
            x_w = x;
        end

        valid_out_d  = s2_q.valid;
        pixel_out_d  = '0;
        hcount_out_d = '0;
        vcount_out_d = '0;
        if (s2_q.valid) begin
            pixel_out_d  = s2_q.pix;
            vcount_out_d = s2_q.v;
            hcount_out_d = s2_q.oor ? s2_q.base : x_w[10:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mode_q       <= 2'd0;
            amp_q        <= 3'd4;
            s1_q         <= '0;
            s2_q         <= '0;
            valid_out_q  <= 1'b0;
            pixel_out_q  <= '0;
            hcount_out_q <= '0;
            vcount_out_q <= '0;
        end else begin
            mode_q       <= mode_d;
            amp_q        <= amp_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            valid_out_q  <= valid_out_d;
            pixel_out_q  <= pixel_out_d;
            hcount_out_q <= hcount_out_d;
            vcount_out_q <= vcount_out_d;
        end
    end

    assign data_valid_out = valid_out_q;
    assign pixel_out      = pixel_out_q;
    assign hcount_out     = hcount_out_q;
    assign vcount_out     = vcount_out_q;

endmodule
